// File: rtl/subtractor_4_bits_serial.sv
// ---------------------------------------------------------------------------
// subtractor_4_bits_serial
//
// Bit-serial 4-bit subtractor. It computes A - B as A + ~B + 1, one bit per
// clock, LSB first. The carry register starts at 1 to supply the "+1" of the
// two's-complement negation. An accepted start latches the operands. Four RUN
// cycles then produce the four result bits. A single DONE cycle presents the
// result and flags with a one-cycle done pulse.
//
// Configuration macro:
//   SUB4_ZERO_FLAG_EN - when defined, flagZ reports Diff == 0 and updates
//                       with the other flags. When undefined, flagZ is tied
//                       to 0 and no zero-detect logic exists.
//
// Ports:
//   clk    in   1  rising-edge clock
//   rst    in   1  synchronous active-high reset (priority over everything)
//   start  in   1  operation request, sampled only in IDLE
//   A      in   4  minuend
//   B      in   4  subtrahend
//   Diff   out  4  A - B mod 16; bits fill LSB first during RUN
//   Cout   out  1  final serial carry (1 = no unsigned borrow)
//   busy   out  1  high in RUN and DONE
//   done   out  1  one-cycle pulse when Diff and the flags are valid
//   flagN  out  1  sign of the result (Diff[3])
//   flagC  out  1  copy of Cout
//   flagV  out  1  signed overflow of A - B
//   flagZ  out  1  result is zero (0 unless SUB4_ZERO_FLAG_EN)
// ---------------------------------------------------------------------------
module subtractor_4_bits_serial (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [3:0] A,
    input  logic [3:0] B,
    output logic [3:0] Diff,
    output logic       Cout,
    output logic       busy,
    output logic       done,
    output logic       flagN,
    output logic       flagC,
    output logic       flagV,
    output logic       flagZ
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t     state;
    logic [3:0] a_lat;
    logic [3:0] b_lat;
    logic       carry;
    logic [1:0] idx;

    // One full-adder slice that operates on the current bit position.
    logic       a_bit;
    logic       nb_bit;
    logic       sum_bit;
    logic       carry_next;
    logic       last_bit;

    function automatic logic fa_sum(input logic x, input logic y, input logic c);
        return x ^ y ^ c;
    endfunction

    function automatic logic fa_carry(input logic x, input logic y, input logic c);
        return (x & y) | (x & c) | (y & c);
    endfunction

    always_comb begin
        a_bit      = a_lat[idx];
        nb_bit     = ~b_lat[idx];
        sum_bit    = fa_sum(a_bit, nb_bit, carry);
        carry_next = fa_carry(a_bit, nb_bit, carry);
        last_bit   = (idx == 2'd3);
    end

`ifdef SUB4_ZERO_FLAG_EN
    // The lower three bits are already in Diff when the MSB is produced.
    // The zero test therefore combines them with the bit that is arriving.
    logic zero_next;

    always_comb begin
        zero_next = (Diff[2:0] == 3'b000) && !sum_bit;
    end
`else
    assign flagZ = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            a_lat <= 4'd0;
            b_lat <= 4'd0;
            carry <= 1'b0;
            idx   <= 2'd0;
            Diff  <= 4'd0;
            Cout  <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
            flagN <= 1'b0;
            flagC <= 1'b0;
            flagV <= 1'b0;
`ifdef SUB4_ZERO_FLAG_EN
            flagZ <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        // The operands are captured here. Later changes on A/B are ignored.
                        a_lat <= A;
                        b_lat <= B;
                        Diff  <= 4'd0;
                        carry <= 1'b1;
                        idx   <= 2'd0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end
                end

                RUN: begin
                    Diff[idx] <= sum_bit;
                    carry     <= carry_next;
                    idx       <= idx + 2'd1;
                    if (last_bit) begin
                        // The MSB completes the result. All flags are taken from this edge.
                        Cout  <= carry_next;
                        flagC <= carry_next;
                        flagN <= sum_bit;
                        flagV <= (a_lat[3] != b_lat[3]) && (sum_bit != a_lat[3]);
`ifdef SUB4_ZERO_FLAG_EN
                        flagZ <= zero_next;
`endif
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end

                DONE: begin
                    // start is not sampled here. A held start is accepted on the next IDLE edge.
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end

                default: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
